// File: rtl/conv3x3_pe.sv
// 3x3 convolution processing element: 9 signed MACs + bias, requantized to 8 bits, 3-stage valid/ready pipeline.
// Optional build macro CONV_PE_RELU_EN applies ReLU ahead of the output clamp.
module conv3x3_pe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_TAPS   = 9,
  parameter int unsigned ACC_WIDTH  = 20,
  parameter int unsigned SHIFT      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  ifm,
  input  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  wgt,
  input  logic signed [DATA_WIDTH-1:0]         bias,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [DATA_WIDTH-1:0]         out_data,
  output logic                                 out_sat
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`ifndef CONV_PE_RELU_EN
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  logic                          adv;

  logic                          v1_q, v1_d;
  logic signed [PROD_W-1:0]      prod_q [NUM_TAPS];
  logic signed [PROD_W-1:0]      prod_d [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  bias_q, bias_d;

  logic                          v2_q, v2_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]   sum;

  logic                          v3_q, v3_d;
  logic signed [DATA_WIDTH-1:0]  data_q, data_d;
  logic                          sat_q, sat_d;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic signed [DATA_WIDTH-1:0]  quant;
  logic                          quant_sat;

  // Whole pipeline moves together; only a stalled output blocks it.
  always_comb begin
    adv      = !v3_q || out_ready;
    in_ready = adv;
  end

  // Stage 1: per-tap products, bias carried alongside.
  always_comb begin
    v1_d   = v1_q;
    bias_d = bias_q;
    for (int i = 0; i < NUM_TAPS; i++) prod_d[i] = prod_q[i];
    if (adv) begin
      v1_d   = in_valid;
      bias_d = bias;
      for (int i = 0; i < NUM_TAPS; i++)
        prod_d[i] = PROD_W'($signed(ifm[i])) * PROD_W'($signed(wgt[i]));
    end
  end

  // Stage 2: full adder tree; accumulator width covers the worst case.
  always_comb begin
    sum = ACC_WIDTH'(bias_q);
    for (int i = 0; i < NUM_TAPS; i++) sum = sum + ACC_WIDTH'(prod_q[i]);
  end

  always_comb begin
    v2_d  = v2_q;
    acc_d = acc_q;
    if (adv) begin
      v2_d  = v1_q;
      acc_d = sum;
    end
  end

  // Stage 3: floor shift then saturate into the output range.
  always_comb begin
    shifted   = acc_q >>> SHIFT;
    quant     = DATA_WIDTH'(shifted);
    quant_sat = 1'b0;
`ifdef CONV_PE_RELU_EN
    if (shifted[ACC_WIDTH-1]) begin
      quant = '0;
    end else if (shifted > ACC_WIDTH'(OUT_MAX)) begin
      quant     = OUT_MAX;
      quant_sat = 1'b1;
    end
`else
    if (shifted > ACC_WIDTH'(OUT_MAX)) begin
      quant     = OUT_MAX;
      quant_sat = 1'b1;
    end else if (shifted < ACC_WIDTH'(OUT_MIN)) begin
      quant     = OUT_MIN;
      quant_sat = 1'b1;
    end
`endif
  end

  always_comb begin
    v3_d   = v3_q;
    data_d = data_q;
    sat_d  = sat_q;
    if (adv) begin
      v3_d   = v2_q;
      data_d = quant;
      sat_d  = quant_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      bias_q <= '0;
      for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= '0;
      v2_q   <= 1'b0;
      acc_q  <= '0;
      v3_q   <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      bias_q <= bias_d;
      for (int i = 0; i < NUM_TAPS; i++) prod_q[i] <= prod_d[i];
      v2_q   <= v2_d;
      acc_q  <= acc_d;
      v3_q   <= v3_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  always_comb begin
    out_valid = v3_q;
    out_data  = data_q;
    out_sat   = sat_q;
  end

endmodule

// File: tb/tb_conv3x3_pe.sv
// Directed self-checking bench for conv3x3_pe (default parameters, SHIFT=4).
module tb_conv3x3_pe;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [8:0][7:0]  ifm;
  logic [8:0][7:0]  wgt;
  logic [7:0]       bias;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_sat;

  int n_checks = 0;
  int n_errors = 0;

  conv3x3_pe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifm       (ifm),
    .wgt       (wgt),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_uniform(input int iv, input int wv, input int bv);
    for (int j = 0; j < 9; j++) begin
      ifm[j] = 8'(iv);
      wgt[j] = 8'(wv);
    end
    bias = 8'(bv);
  endtask

  // Reference: exact dot product, floor shift by 4, clamp.
  task automatic model(input logic [8:0][7:0] f, input logic [8:0][7:0] w,
                       input logic [7:0] b, output int d, output int s);
    int acc;
    int t;
    acc = int'($signed(b));
    for (int j = 0; j < 9; j++) acc += int'($signed(f[j])) * int'($signed(w[j]));
    t = acc >>> 4;
    s = 0;
    d = t;
`ifdef CONV_PE_RELU_EN
    if (t < 0) d = 0;
    else if (t > 127) begin d = 127; s = 1; end
`else
    if (t > 127) begin d = 127; s = 1; end
    else if (t < -128) begin d = -128; s = 1; end
`endif
  endtask

  // Single window with uniform taps; called aligned to a falling edge.
  task automatic run_single(input string tag, input int iv, input int wv, input int bv,
                            input int exp_d, input int exp_s);
    int lat;
    set_uniform(iv, wv, bv);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, int'($signed(out_data)), exp_d);
    check({tag, "_sat"}, int'(out_sat), exp_s);
  endtask

  logic [8:0][7:0] s_ifm [10];
  logic [8:0][7:0] s_wgt [10];
  logic [7:0]      s_bias [10];
  int exp_d_q [$];
  int exp_s_q [$];

  initial begin
    int sent;
    int recv;
    int ed;
    int es;
    int cyc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_uniform(0, 0, 0);

    // Test 1: reset state and release
    repeat (2) begin
      @(negedge clk);
      check("t1_rst_out_valid", int'(out_valid), 0);
      check("t1_rst_out_data", int'(out_data), 0);
      check("t1_rst_out_sat", int'(out_sat), 0);
    end
    rst = 1'b0;
    #1 check("t1_in_ready_after_release", int'(in_ready), 1);
    @(negedge clk);

    // Tests 2-4: single windows
    run_single("t2", 2, 3, 6, 3, 0);
    @(negedge clk);
    run_single("t3", -128, -128, 127, 127, 1);
    @(negedge clk);
`ifdef CONV_PE_RELU_EN
    run_single("t4", 10, -10, 0, 0, 0);
`else
    run_single("t4", 10, -10, 0, -57, 0);
`endif
    @(negedge clk);

    // Test 5: back-to-back stream with an output stall
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 9; j++) begin
        s_ifm[k][j] = 8'(k * 29 + j * 17 - 100);
        s_wgt[k][j] = 8'(j * 23 - k * 31 + 5);
      end
      s_bias[k] = 8'(k * 13 - 60);
    end
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 10 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 10);
      if (sent < 10) begin
        ifm  = s_ifm[sent];
        wgt  = s_wgt[sent];
        bias = s_bias[sent];
      end
      #1;
      check("t5_in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_d_q.size() == 0) begin
          check("t5_unexpected_output", 1, 0);
        end else begin
          ed = exp_d_q.pop_front();
          es = exp_s_q.pop_front();
          check("t5_data", int'($signed(out_data)), ed);
          check("t5_sat", int'(out_sat), es);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        model(s_ifm[sent], s_wgt[sent], s_bias[sent], ed, es);
        exp_d_q.push_back(ed);
        exp_s_q.push_back(es);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    check("t5_received", recv, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      #1 check("t5_no_duplicate", int'(out_valid), 0);
      @(negedge clk);
    end

    // Test 6: reset with windows in flight
    set_uniform(5, 5, 0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_uniform(4, 4, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 check("t6_pre_reset_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("t6_reset_out_valid", int'(out_valid), 0);
    check("t6_reset_out_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t6_no_stale", int'(out_valid), 0);
    end
    run_single("t6_next", 2, 3, 6, 3, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
